// File: rtl/memc_pkg.sv
// memc_pkg: state indices and BIST test-pattern helpers shared by the memory controller
package memc_pkg;
  typedef enum logic [3:0] {
    S_RESET, S_WR1, S_RD1, S_CK1, S_WR2, S_RD2, S_CK2, S_ERROR, S_IDLE, S_READ, S_WRITE
  } st_idx_t;
  localparam int N_STATES = 11;
  function automatic logic [63:0] patt_a(input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w && i < 64; i += 2) r[i] = 1'b1;
    return r;
  endfunction
  function automatic logic [63:0] patt_b(input int w);
    return ~patt_a(w);
  endfunction
endpackage

// File: rtl/memc_bram.sv
// memc_bram: single-port synchronous RAM, read-first, one-cycle registered read
module memc_bram #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  // write on we, always register the addressed word
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata <= mem_q[addr];
  end
endmodule

// File: rtl/memc_ctrl.sv
// memc_ctrl: single-request memory controller with optional post-reset BIST (MEMC_BIST_EN)
module memc_ctrl import memc_pkg::*; #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int BIST_LAST = 2**ADDR_W-1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  input  logic              wr_en,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_valid,
  output logic              bist_done,
  output logic              bist_err,
  output logic [ADDR_W-1:0] err_addr
);
  logic [N_STATES-1:0] state_q, state_d;
  st_idx_t nxt;
  logic [DATA_W-1:0] rdata_q, rdata_d, ram_rdata, ram_wdata;
  logic [ADDR_W-1:0] ram_addr;
  logic ram_we, rd_acc, wr_acc, bist_done_q, bist_done_d;
  assign rd_acc    = state_q[S_IDLE] && rd_en;
  assign wr_acc    = state_q[S_IDLE] && wr_en && !rd_en;
  assign busy      = !state_q[S_IDLE];
  assign rd_valid  = state_q[S_READ];
  assign rdata     = state_q[S_READ] ? ram_rdata : rdata_q;
  assign bist_done = bist_done_q;
  assign rdata_d     = reset ? rdata : '0;
  assign bist_done_d = reset && (bist_done_q || state_d[S_IDLE] || state_d[S_ERROR]);
`ifdef MEMC_BIST_EN
  localparam logic [DATA_W-1:0] PA   = DATA_W'(patt_a(DATA_W));
  localparam logic [DATA_W-1:0] PB   = DATA_W'(patt_b(DATA_W));
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BIST_LAST);
  logic [ADDR_W-1:0] bist_addr_q, bist_addr_d, err_addr_q, err_addr_d;
  logic bist_err_q, bist_err_d, ck1_ok, ck2_ok;
  assign ck1_ok    = ram_rdata == PA;
  assign ck2_ok    = ram_rdata == PB;
  assign ram_we    = reset && (wr_acc || state_q[S_WR1] || state_q[S_WR2]);
  assign ram_addr  = state_q[S_IDLE] ? addr : bist_addr_q;
  assign ram_wdata = state_q[S_IDLE] ? wdata : state_q[S_WR1] ? PA : PB;
  assign bist_err  = bist_err_q;
  assign err_addr  = err_addr_q;
  // BIST address walk and sticky error capture of the failing address
  always_comb begin
    bist_addr_d = !reset ? '0 : (state_q[S_CK2] && ck2_ok && bist_addr_q != LAST) ? bist_addr_q + 1'b1 : bist_addr_q;
    bist_err_d  = reset && (bist_err_q || state_d[S_ERROR]);
    err_addr_d  = !reset ? '0 : (state_d[S_ERROR] && !state_q[S_ERROR]) ? bist_addr_q : err_addr_q;
  end
  // BIST registers
  always_ff @(posedge clk) begin
    bist_addr_q <= bist_addr_d;
    bist_err_q  <= bist_err_d;
    err_addr_q  <= err_addr_d;
  end
`else
  assign ram_we    = reset && wr_acc;
  assign ram_addr  = addr;
  assign ram_wdata = wdata;
  assign bist_err  = 1'b0;
  assign err_addr  = '0;
`endif
  // one-hot next state; reset overrides everything
  always_comb begin
    nxt = S_RESET;
    if (state_q[S_IDLE]) nxt = rd_acc ? S_READ : wr_acc ? S_WRITE : S_IDLE;
    if (state_q[S_READ] || state_q[S_WRITE]) nxt = S_IDLE;
`ifdef MEMC_BIST_EN
    if (state_q[S_RESET]) nxt = S_WR1;
    if (state_q[S_WR1]) nxt = S_RD1;
    if (state_q[S_RD1]) nxt = S_CK1;
    if (state_q[S_CK1]) nxt = ck1_ok ? S_WR2 : S_ERROR;
    if (state_q[S_WR2]) nxt = S_RD2;
    if (state_q[S_RD2]) nxt = S_CK2;
    if (state_q[S_CK2]) nxt = !ck2_ok ? S_ERROR : (bist_addr_q == LAST) ? S_IDLE : S_WR1;
    if (state_q[S_ERROR]) nxt = S_ERROR;
`else
    if (state_q[S_RESET]) nxt = S_IDLE;
    if (|state_q[S_ERROR:S_WR1]) nxt = S_RESET;
`endif
    if (!reset) nxt = S_RESET;
    state_d = '0;
    state_d[nxt] = 1'b1;
  end
  // state and user-path output registers; reset is folded into the _d terms
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    rdata_q     <= rdata_d;
    bist_done_q <= bist_done_d;
  end
  memc_bram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bram (
    .clk(clk), .we(ram_we), .addr(ram_addr), .wdata(ram_wdata), .rdata(ram_rdata)
  );
endmodule

// File: tb/tb_memc_ctrl.sv
// tb_memc_ctrl: table-driven and randomized checks of memc_ctrl against a word-array model
module tb_memc_ctrl;
  localparam int AW = 4, DW = 8, LAST = 15;
  typedef struct {
    bit rd; bit wr; logic [AW-1:0] a; logic [DW-1:0] d; bit chk; logic [DW-1:0] exp;
  } vec_t;
  logic clk = 0, reset = 0, rd_en = 0, wr_en = 0, busy, rd_valid, bist_done, bist_err;
  logic [AW-1:0] addr = '0, err_addr;
  logic [DW-1:0] wdata = '0, rdata;
  int errors = 0, checks = 0;
  logic [DW-1:0] mem_m [2**AW];
  bit known [2**AW];
  vec_t vecs [10];
  always #5 clk = ~clk;
  memc_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BIST_LAST(LAST)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .rd_en(rd_en), .wr_en(wr_en),
    .busy(busy), .rdata(rdata), .rd_valid(rd_valid), .bist_done(bist_done),
    .bist_err(bist_err), .err_addr(err_addr)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_bist_done"}, bist_done, 0);
    chk({tag, "_bist_err"}, bist_err, 0);
    chk({tag, "_err_addr"}, err_addr, 0);
  endtask
  task automatic wait_ready(input string tag);
`ifdef MEMC_BIST_EN
    repeat (96) tick();
    chk({tag, "_done_early"}, bist_done, 0);
    chk({tag, "_busy_early"}, busy, 1);
    tick();
    for (int i = 0; i < 2**AW; i++) begin mem_m[i] = 8'hAA; known[i] = 1; end
`else
    tick();
`endif
    chk({tag, "_done"}, bist_done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, bist_err, 0);
    chk({tag, "_err_addr"}, err_addr, 0);
  endtask
  task automatic req(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     output logic [DW-1:0] got);
    int n = 0;
    while (busy && n < 300) begin tick(); n++; end
    if (busy) begin chk("busy_timeout", busy, 0); got = 'x; return; end
    rd_en = rd; wr_en = wr; addr = a; wdata = d;
    tick();
    rd_en = 1; wr_en = 1; addr = AW'($urandom); wdata = DW'($urandom);
    chk(rd ? "rd_valid_t1" : "rd_valid_wr_t1", rd_valid, 32'(rd));
    chk("busy_t1", busy, 1);
    got = rdata;
    tick();
    rd_en = 0; wr_en = 0;
    chk("rd_valid_t2", rd_valid, 0);
    chk("busy_t2", busy, 0);
    if (rd) chk("rdata_hold", rdata, got);
    if (rd && known[a]) chk("model_rd", got, mem_m[a]);
    else if (wr && !rd) begin mem_m[a] = d; known[a] = 1; end
  endtask
  initial begin
    logic [DW-1:0] got;
    int r;
    vecs[0] = '{0, 1, 4'd7,  8'h3C, 0, 8'h00};
    vecs[1] = '{1, 0, 4'd7,  8'h00, 1, 8'h3C};
    vecs[2] = '{1, 1, 4'd7,  8'h00, 1, 8'h3C};
    vecs[3] = '{1, 0, 4'd7,  8'h00, 1, 8'h3C};
    vecs[4] = '{0, 1, 4'd0,  8'h81, 0, 8'h00};
    vecs[5] = '{1, 0, 4'd0,  8'h00, 1, 8'h81};
    vecs[6] = '{0, 1, 4'd15, 8'h5A, 0, 8'h00};
    vecs[7] = '{0, 1, 4'd14, 8'hC3, 0, 8'h00};
    vecs[8] = '{1, 0, 4'd15, 8'h00, 1, 8'h5A};
    vecs[9] = '{1, 0, 4'd14, 8'h00, 1, 8'hC3};
    for (int i = 0; i < 2**AW; i++) known[i] = 0;
    tick();
    tick();
    chk_reset_vals("por");
    reset = 1;
    wait_ready("boot");
`ifdef MEMC_BIST_EN
    req(1, 0, 4'd3, 8'h00, got);
    chk("bist_patt_b", got, 8'hAA);
`endif
    for (int i = 0; i < 10; i++) begin
      req(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, got);
      if (vecs[i].chk) chk($sformatf("vec%0d_rdata", i), got, vecs[i].exp);
    end
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 3);
      if (r == 0) repeat ($urandom_range(1, 2)) tick();
      else req(r != 2, r != 1, AW'($urandom), DW'($urandom), got);
    end
    chk("err_quiet", bist_err, 0);
`ifdef MEMC_BIST_EN
    reset = 0;
    tick();
    reset = 1;
    repeat (57) tick();
    reset = 0;
    tick();
    chk_reset_vals("midbist");
    reset = 1;
    wait_ready("rebist");
    req(1, 0, 4'd9, 8'h00, got);
    chk("rebist_rd9", got, 8'hAA);
    reset = 0;
    tick();
    reset = 1;
    repeat (32) tick();
    force dut.ram_rdata = 8'h54;
    tick();
    chk("err_done_pre", bist_done, 0);
    tick();
    release dut.ram_rdata;
    chk("err_flag", bist_err, 1);
    chk("err_done", bist_done, 1);
    chk("err_addr", err_addr, 5);
    chk("err_busy", busy, 1);
    rd_en = 1;
    addr = 4'd3;
    repeat (5) begin
      tick();
      chk("err_no_rd", rd_valid, 0);
      chk("err_busy_hold", busy, 1);
    end
    rd_en = 0;
    chk("err_addr_hold", err_addr, 5);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
